// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions five asynchronous pushbuttons (bit 0=P, 1=R, 2=L, 3=U, 4=D) into
// clean, registered levels and single-cycle press pulses for the user-control
// FSM. Each channel is handled independently by identical logic:
//   2-flop synchronizer -> debounce counter -> pulse generator
// and, on bits 3 and 4 only, an optional auto-repeat counter.
//
// Compile-time option:
//   AUTOREPEAT_EN  When defined, U/D (bits 3, 4) emit extra pulses while held:
//                  the first REPEAT_DELAY cycles after the press pulse, then
//                  every REPEAT_PERIOD cycles until release. When undefined,
//                  no repeat hardware exists and every bit pulses once per press.
//
// Parameters (each must be in 1 .. 2^27-1):
//   DEBOUNCE_CYCLES  consecutive stable cycles before btn_level changes
//   REPEAT_DELAY     cycles from press pulse to first repeat pulse
//   REPEAT_PERIOD    cycles between later repeat pulses
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high; clears all state
//   btn_raw    in   5  asynchronous button inputs
//   btn_pulse  out  5  one-cycle press events (registered)
//   btn_level  out  5  debounced levels (registered)
//
// Output timing: with edge 1 being the first edge that samples a held
// btn_raw[i]=1, btn_level[i] and btn_pulse[i] rise together after edge
// DEBOUNCE_CYCLES+2. Releases use the same latency and never pulse.
// Simultaneous presses pulse simultaneously; there is no arbitration here.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_pulse,
  output logic [4:0] btn_level
);

  localparam int NB = 5;
  localparam int CW = 27;

  localparam logic [CW-1:0] DB_TARGET = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE       = CW'(1);

  // Synchronizer, debounced level and pulse registers
  logic [NB-1:0] sync1_q, sync1_d;
  logic [NB-1:0] sync2_q, sync2_d;
  logic [NB-1:0] level_q, level_d;
  logic [NB-1:0] pulse_q, pulse_d;

  // Per-channel debounce counters
  logic [CW-1:0] db_cnt_q [NB];
  logic [CW-1:0] db_cnt_d [NB];

  // High for the one edge on which a channel's debounced level changes
  logic [NB-1:0] flip;

`ifdef AUTOREPEAT_EN
  localparam logic [CW-1:0] RPT_DELAY  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RPT_PERIOD = CW'(REPEAT_PERIOD);

  // Repeat counters for bits 3 and 4 (index 0 -> bit 3, index 1 -> bit 4).
  // They count down to the next repeat pulse: loaded with REPEAT_DELAY on the
  // press pulse, reloaded with REPEAT_PERIOD on each repeat pulse, and held at
  // 0 while the button is released. A pulse fires on the edge where the count
  // is 1, i.e. exactly N edges after the load.
  logic [CW-1:0] rpt_cnt_q [2];
  logic [CW-1:0] rpt_cnt_d [2];
`endif

  // ---------------------------------------------------------------------------
  // Synchronizer and debounce
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    flip    = '0;
    for (int i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        // Flip on the edge the count would reach the target; the counter
        // clears on that same edge so the next change starts from zero.
        if (db_cnt_q[i] + ONE == DB_TARGET) begin
          level_d[i] = sync2_q[i];
          flip[i]    = 1'b1;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pulse generation (press edge, plus optional auto-repeat on bits 3/4)
  // ---------------------------------------------------------------------------
  always_comb begin
    // Press pulse only on a 0->1 flip; releases never pulse.
    pulse_d = flip & sync2_q;
`ifdef AUTOREPEAT_EN
    for (int j = 0; j < 2; j++) begin
      rpt_cnt_d[j] = rpt_cnt_q[j];
      if (!level_d[j+3]) begin
        // Released (or releasing this edge): stop immediately, no pulse.
        rpt_cnt_d[j] = '0;
      end else if (flip[j+3]) begin
        rpt_cnt_d[j] = RPT_DELAY;
      end else if (rpt_cnt_q[j] == ONE) begin
        rpt_cnt_d[j]   = RPT_PERIOD;
        pulse_d[j+3]   = 1'b1;
      end else if (rpt_cnt_q[j] != '0) begin
        rpt_cnt_d[j] = rpt_cnt_q[j] - ONE;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i] <= '0;
      end
`ifdef AUTOREPEAT_EN
      for (int j = 0; j < 2; j++) begin
        rpt_cnt_q[j] <= '0;
      end
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
`ifdef AUTOREPEAT_EN
      for (int j = 0; j < 2; j++) begin
        rpt_cnt_q[j] <= rpt_cnt_d[j];
      end
`endif
    end
  end

  assign btn_pulse = pulse_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8). Directed scenarios followed by randomized buttons and
// resets. Every cycle the DUT outputs are compared against a reference model
// that derives levels from the history of sampled inputs (a level changes once
// the last DEBOUNCE_CYCLES synchronized samples all disagree with it) and
// derives repeat pulses from the time elapsed since the press pulse.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic [4:0] btn_pulse;
  logic [4:0] btn_level;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_pulse (btn_pulse),
    .btn_level (btn_level)
  );

  // Scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [4:0] hist_q[$];   // btn_raw as sampled at each edge (zeros after reset)
  logic [4:0] lvl_m;
  logic [4:0] pls_m;
  int         t_m [5];     // edges since press pulse

  // Per-scenario observations
  int         edge_n;
  int         pcount [5];
  int         first_pulse [5];
  logic [4:0] lvl_seen;

`ifdef AUTOREPEAT_EN
  localparam int EXP_U_PULSES = 6;
`else
  localparam int EXP_U_PULSES = 1;
`endif

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (scenario edge %0d)", tag, obs, exp, edge_n);
  endtask

  // Advance the model by one clock edge.
  task automatic model_edge(input logic [4:0] raw, input logic rst);
    logic [4:0] nl;
    logic [4:0] np;
    logic [4:0] e;
    logic       x;
    logic       all_same;
    int         sz;
    if (rst) begin
      hist_q.delete();
      for (int k = 0; k < D + 2; k++) hist_q.push_back(5'b0);
      lvl_m = '0;
      pls_m = '0;
      return;
    end
    nl = lvl_m;
    np = '0;
    sz = hist_q.size();
    for (int i = 0; i < 5; i++) begin
      // The debouncer at this edge sees the sample taken two edges earlier;
      // it flips once the last D such samples all disagree with the level.
      e = hist_q[sz-2];
      x = e[i];
      all_same = 1'b1;
      for (int k = 1; k <= D; k++) begin
        e = hist_q[sz-1-k];
        if (e[i] != x) all_same = 1'b0;
      end
      if (all_same && (x != lvl_m[i])) begin
        nl[i] = x;
        if (x) begin
          np[i]  = 1'b1;
          t_m[i] = 0;
        end
      end else if (lvl_m[i]) begin
        t_m[i]++;
`ifdef AUTOREPEAT_EN
        if (i >= 3 && (t_m[i] == RD || (t_m[i] > RD && (t_m[i] - RD) % RP == 0)))
          np[i] = 1'b1;
`endif
      end
    end
    hist_q.push_back(raw);
    if (hist_q.size() > D + 4) void'(hist_q.pop_front());
    lvl_m = nl;
    pls_m = np;
  endtask

  task automatic clear_stats();
    edge_n   = 0;
    lvl_seen = '0;
    for (int i = 0; i < 5; i++) begin
      pcount[i]      = 0;
      first_pulse[i] = -1;
    end
  endtask

  // Drive one cycle, then compare both outputs against the model.
  task automatic step(input logic [4:0] raw, input logic rst);
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    model_edge(raw, rst);
    #1;
    edge_n++;
    lvl_seen = lvl_seen | btn_level;
    for (int i = 0; i < 5; i++) begin
      if (btn_pulse[i]) begin
        pcount[i]++;
        if (first_pulse[i] < 0) first_pulse[i] = edge_n;
      end
    end
    check("pulse_vs_model", int'(btn_pulse), int'(pls_m));
    check("level_vs_model", int'(btn_level), int'(lvl_m));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(5'b0, 1'b0);
  endtask

  logic [4:0] rnd_raw;
  logic       rnd_rst;

  initial begin
    btn_raw = '0;
    reset   = 1'b1;

    // Reset state
    step(5'b0, 1'b1);
    step(5'b0, 1'b1);
    check("reset_pulse", int'(btn_pulse), 0);
    check("reset_level", int'(btn_level), 0);

    // Clean press and release on P
    clear_stats();
    repeat (12) step(5'b00001, 1'b0);
    check("clean_pulse_count", pcount[0], 1);
    check("clean_pulse_edge", first_pulse[0], D + 2);
    check("clean_level_held", int'(btn_level[0]), 1);
    clear_stats();
    repeat (D + 1) step(5'b0, 1'b0);
    check("release_level_before", int'(btn_level[0]), 1);
    step(5'b0, 1'b0);
    check("release_level_after", int'(btn_level[0]), 0);
    check("release_no_pulse", pcount[0], 0);
    idle(4);

    // Bounce on R: 1,0,1,0 then hold; final rise on scenario edge 5
    clear_stats();
    step(5'b00010, 1'b0);
    step(5'b00000, 1'b0);
    step(5'b00010, 1'b0);
    step(5'b00000, 1'b0);
    repeat (12) step(5'b00010, 1'b0);
    check("bounce_pulse_count", pcount[1], 1);
    check("bounce_pulse_edge", first_pulse[1], 5 + D + 1);
    idle(10);

    // Glitch on L: 3 cycles high
    clear_stats();
    repeat (3) step(5'b00100, 1'b0);
    idle(10);
    check("glitch_pulse_count", pcount[2], 0);
    check("glitch_level_seen", int'(lvl_seen[2]), 0);

    // Long hold on U (auto-repeat when enabled)
    clear_stats();
    repeat (60) step(5'b01000, 1'b0);
    idle(10);
    check("repeat_pulse_count", pcount[3], EXP_U_PULSES);
    check("repeat_first_edge", first_pulse[3], D + 2);

    // Simultaneous P and D
    clear_stats();
    repeat (10) step(5'b10001, 1'b0);
    check("simul_p_edge", first_pulse[0], D + 2);
    check("simul_d_edge", first_pulse[4], D + 2);
    idle(10);

    // Reset two cycles into a debounce, button still held afterwards
    clear_stats();
    step(5'b00010, 1'b0);
    step(5'b00010, 1'b0);
    step(5'b00010, 1'b1);
    check("midreset_pulse", int'(btn_pulse), 0);
    check("midreset_level", int'(btn_level), 0);
    step(5'b00010, 1'b1);
    clear_stats();
    repeat (10) step(5'b00010, 1'b0);
    check("postreset_pulse_count", pcount[1], 1);
    check("postreset_pulse_edge", first_pulse[1], D + 2);
    idle(10);

    // Randomized buttons with occasional resets
    rnd_raw = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (i >= 3) begin
          if ($urandom_range(39, 0) == 0) rnd_raw[i] = ~rnd_raw[i];
        end else begin
          if ($urandom_range(5, 0) == 0) rnd_raw[i] = ~rnd_raw[i];
        end
      end
      rnd_rst = ($urandom_range(99, 0) == 0);
      step(rnd_raw, rnd_rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 1000000; consecutive stable cycles required before the debounced level changes.
- REQ-002: Parameter REPEAT_DELAY, default 50000000; cycles from the initial press pulse to the first auto-repeat pulse.
- REQ-003: Parameter REPEAT_PERIOD, default 10000000; cycles between later auto-repeat pulses.
- REQ-004: clk  input  1  system clock; all logic on the rising edge.
- REQ-005: reset  input  1  reset, synchronous, active-high.
- REQ-006: btn_raw  input  5  asynchronous pushbutton inputs; bit 0=P, 1=R, 2=L, 3=U, 4=D.
- REQ-007: btn_pulse  output  5  single-cycle press events, same bit order; feeds the BTNP/BTNR/BTNL/BTNU/BTND inputs of the user-control FSM.
- REQ-008: btn_level  output  5  debounced button levels, same bit order.

Function
- REQ-009: Each channel SHALL be conditioned independently by identical logic: a 2-flop synchronizer, a debounce counter, a pulse generator and (bits 3 and 4 only) a repeat counter.
- REQ-010: All counters SHALL be 27 bits wide; every parameter SHALL be in the range 1 to 2^27-1.
- REQ-011: Debounce counter: while sync2[i] equals btn_level[i], the counter SHALL clear to 0; otherwise it SHALL increment.
- REQ-012: Debounce flip: when the counter would reach DEBOUNCE_CYCLES, btn_level[i] SHALL take sync2[i] and the counter SHALL clear in the same edge.
- REQ-013: Glitch rejection: a glitch shorter than DEBOUNCE_CYCLES stable cycles SHALL NOT change btn_level.
- REQ-014: Press latency: with edge 1 defined as the first edge that samples btn_raw[i]=1, btn_level[i] and btn_pulse[i] SHALL both go high after edge DEBOUNCE_CYCLES+2, provided the input is held.
- REQ-015: Release latency: the release transition SHALL use the same latency as a press and SHALL generate no pulse.
- REQ-016: btn_pulse[i] SHALL be high for exactly one cycle per 0-to-1 transition of btn_level[i], plus any repeat pulses defined by REQ-023.
- REQ-017: Simultaneous presses SHALL produce simultaneous pulses with no arbitration; priority resolution belongs to the downstream FSM.
- REQ-018: All outputs SHALL be registered, with no combinational path from btn_raw.

Reset
- REQ-019: On reset, the synchronizers, btn_level, btn_pulse and all counters SHALL clear to 0 on the next clock edge.
- REQ-020: Reset asserted mid-debounce or mid-repeat SHALL abort the operation; no pulse SHALL be emitted in the cycle after reset.
- REQ-021: A button held through reset deassertion SHALL be treated as a new press: one pulse after DEBOUNCE_CYCLES+2 edges, counted from the first edge with reset low.

Configuration
- REQ-022: Macro AUTOREPEAT_EN SHALL select auto-repeat on bits 3 (U) and 4 (D).
- REQ-023: With AUTOREPEAT_EN defined, the following SHALL apply to bits 3 and 4:
  - while btn_level[i]=1, the repeat counter counts from the initial pulse;
  - an extra one-cycle pulse is emitted REPEAT_DELAY cycles after the initial pulse;
  - further pulses follow every REPEAT_PERIOD cycles until release;
  - release clears the repeat counter immediately.
- REQ-024: With AUTOREPEAT_EN undefined, the repeat counters SHALL NOT be synthesized, and all five bits SHALL emit exactly one pulse per press.
- REQ-025: Bits 0-2 SHALL never auto-repeat in either configuration.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
- REQ-026: Clean press: btn_raw[0] rises and holds -> btn_pulse[0] high for exactly one cycle after edge 6, btn_level[0]=1 thereafter; release -> btn_level[0]=0 six edges later, no pulse.
- REQ-027: Bounce: btn_raw[1] toggles 1,0,1,0 (one cycle each), then holds 1 -> exactly one btn_pulse[1], 6 edges after the final rise.
- REQ-028: Glitch: btn_raw[2] high for 3 cycles, then low -> btn_level[2] and btn_pulse[2] stay 0.
- REQ-029: Auto-repeat, AUTOREPEAT_EN defined: btn_raw[3] held 60 cycles -> pulses at debounce+0, +20, +28, +36, +44, +52; with the macro undefined -> one pulse only.
- REQ-030: Simultaneous and reset:
  - btn_raw[0] and btn_raw[4] rise on the same edge -> both pulses high in the same cycle;
  - reset asserted 2 cycles into a debounce -> no pulse, all outputs 0;
  - input still held after reset release -> one pulse 6 edges after reset release.
